// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode-stage issue bundle between the D stage (master) and the hazard scoreboard (slave).
// Latency: stall/issue outputs are combinational in the D-stage cycle; stall_cycles is registered.
// Backpressure: stallF/stallD hold the D instruction; flushD squashes it without stalling.
// Ports: D-instruction fields (issue_valid, RsD/RtD/RdD, useRs/useRt, writesReg, lat, is_md, flushD)
//        flow master->slave; pipeline controls and the stall counter flow slave->master.
interface hazard_scoreboard_ctrl_if #(
    parameter int LAT_W  = 3,
    parameter int PERF_W = 32
);
    logic              issue_valid;
    logic [4:0]        RsD;
    logic [4:0]        RtD;
    logic              useRs;
    logic              useRt;
    logic              writesReg;
    logic [4:0]        RdD;
    logic [LAT_W-1:0]  lat;
    logic              is_md;
    logic              flushD;

    logic              stallF;
    logic              stallD;
    logic              flushE;
    logic              issued;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output issue_valid, RsD, RtD, useRs, useRt, writesReg, RdD, lat, is_md, flushD,
        input  stallF, stallD, flushE, issued, md_busy, stall_cycles
    );

    modport slave (
        input  issue_valid, RsD, RtD, useRs, useRt, writesReg, RdD, lat, is_md, flushD,
        output stallF, stallD, flushE, issued, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage issue controller: per-GPR countdown scoreboard plus MDU occupancy counter.
// Latency: issue/stall decision is combinational in the same cycle; state updates on the next edge.
// Backpressure: any RAW/WAW/MDU hazard stalls F and D and bubbles EX; flushD overrides a stall.
// Ports: clk, rst_n (synchronous, active low), bus (slave modport of hazard_scoreboard_ctrl_if).
module hazard_scoreboard_ctrl #(
    parameter int LAT_W  = 3,
    parameter int MD_LAT = 8,
    parameter int PERF_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_scoreboard_ctrl_if.slave   bus
);

    localparam logic [7:0] MD_LAT_V = 8'(MD_LAT);

    // cnt[r] = cycles until GPR r is readable by a consumer in D; $0 has no entry.
    logic [LAT_W-1:0]  cnt [1:31];
    logic [7:0]        md_cnt;
    logic [PERF_W-1:0] stall_cnt;

    logic [31:0] pend;
    logic        md_busy_int;
    logic        raw;
    logic        waw;
    logic        struct_haz;
    logic        hazard;
    logic        stall;
    logic        issue;
    logic        set_dst;

    // Pending bitmap; bit 0 stays clear so reads/writes of $0 never hazard.
    always_comb begin
        pend = '0;
        for (int r = 1; r < 32; r++) begin
            pend[r] = (cnt[r] != '0);
        end
    end

    assign md_busy_int = (md_cnt != 8'd0);

    // An instruction with RsD == RtD == pending register is still a single hazard.
    assign raw        = (bus.useRs && pend[bus.RsD]) || (bus.useRt && pend[bus.RtD]);
    assign waw        = bus.writesReg && pend[bus.RdD];
    assign struct_haz = bus.is_md && md_busy_int;
    assign hazard     = bus.issue_valid && (raw || waw || struct_haz);

    // flushD wins: a squashed instruction neither stalls nor touches the scoreboard.
    assign stall = rst_n && hazard && !bus.flushD;
    assign issue = rst_n && bus.issue_valid && !hazard && !bus.flushD;

    // lat == 0 means fully bypassed, so nothing needs tracking.
    assign set_dst = issue && bus.writesReg && (bus.RdD != 5'd0) && (bus.lat != '0);

    assign bus.stallF       = stall;
    assign bus.stallD       = stall;
    assign bus.flushE       = stall;
    assign bus.issued       = issue;
    assign bus.md_busy      = rst_n && md_busy_int;
    assign bus.stall_cycles = stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
            md_cnt    <= 8'd0;
            stall_cnt <= '0;
        end else begin
            // Countdown first; a new producer's load overrides its own decrement.
            for (int r = 1; r < 32; r++) begin
                if (set_dst && (bus.RdD == 5'(r))) begin
                    cnt[r] <= bus.lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end

            if (issue && bus.is_md) begin
                md_cnt <= MD_LAT_V;
            end else if (md_cnt != 8'd0) begin
                md_cnt <= md_cnt - 8'd1;
            end

            // Saturating performance counter: holds at all-ones.
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl: directed scenarios followed by random traffic.
// Expected outputs come from a cycle-timestamp reference model and are checked by a separate monitor.
// PERF_W is narrowed to 4 so stall-counter saturation is reached.
module tb_hazard_scoreboard_ctrl;

    localparam int LAT_W   = 3;
    localparam int MD_LAT  = 8;
    localparam int PERF_W  = 4;
    localparam int SC_MAX  = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(.LAT_W(LAT_W), .PERF_W(PERF_W)) bus ();

    hazard_scoreboard_ctrl #(
        .LAT_W (LAT_W),
        .MD_LAT(MD_LAT),
        .PERF_W(PERF_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        bit         v;
        logic [4:0] rs;
        bit         urs;
        logic [4:0] rt;
        bit         urt;
        logic [4:0] rd;
        bit         wr;
        logic [2:0] l;
        bit         md;
        bit         fl;
    } ins_t;

    typedef struct {
        bit              stall;
        bit              issued;
        bit              md_busy;
        logic [PERF_W-1:0] sc;
    } exp_t;

    exp_t expq[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: absolute cycle at which each register / the MDU becomes free.
    int unsigned cyc;
    int unsigned ready_at [32];
    int unsigned md_ready;
    int unsigned sc_m;

    function automatic ins_t mk(bit v, int rs, bit urs, int rt, bit urt,
                                int rd, bit wr, int l, bit md, bit fl);
        ins_t i;
        i.v = v; i.rs = 5'(rs); i.urs = urs; i.rt = 5'(rt); i.urt = urt;
        i.rd = 5'(rd); i.wr = wr; i.l = 3'(l); i.md = md; i.fl = fl;
        return i;
    endfunction

    function automatic bit pending(logic [4:0] r);
        return (r != 5'd0) && (cyc < ready_at[r]);
    endfunction

    task automatic model_clear();
        cyc = 0;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        md_ready = 0;
        sc_m = 0;
    endtask

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    // Drive one D-stage cycle, queue its expected response, then advance the model at the edge.
    task automatic step(input ins_t i);
        exp_t e;
        bit   raw, waw, mbusy, haz;
        bus.issue_valid = i.v;
        bus.RsD         = i.rs;
        bus.useRs       = i.urs;
        bus.RtD         = i.rt;
        bus.useRt       = i.urt;
        bus.RdD         = i.rd;
        bus.writesReg   = i.wr;
        bus.lat         = i.l;
        bus.is_md       = i.md;
        bus.flushD      = i.fl;

        raw   = (i.urs && pending(i.rs)) || (i.urt && pending(i.rt));
        waw   = i.wr && pending(i.rd);
        mbusy = (cyc < md_ready);
        haz   = i.v && (raw || waw || (i.md && mbusy));
        e.stall   = rst_n && haz && !i.fl;
        e.issued  = rst_n && i.v && !haz && !i.fl;
        e.md_busy = rst_n && mbusy;
        e.sc      = PERF_W'(sc_m);
        expq.push_back(e);

        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (e.stall && sc_m < SC_MAX) sc_m++;
            if (e.issued && i.wr && i.rd != 5'd0 && i.l != 3'd0)
                ready_at[i.rd] = cyc + i.l + 1;
            if (e.issued && i.md)
                md_ready = cyc + MD_LAT + 1;
            cyc++;
        end
        #2;
    endtask

    function automatic logic [4:0] rnd_reg();
        return 5'($urandom_range(0, 5));
    endfunction

    // Monitor: every cycle the DUT presents a decision; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("stallF",       int'(bus.stallF),       int'(e.stall));
                check("stallD",       int'(bus.stallD),       int'(e.stall));
                check("flushE",       int'(bus.flushE),       int'(e.stall));
                check("issued",       int'(bus.issued),       int'(e.issued));
                check("md_busy",      int'(bus.md_busy),      int'(e.md_busy));
                check("stall_cycles", int'(bus.stall_cycles), int'(e.sc));
            end
        end
    end

    initial begin
        ins_t nop, i;
        model_clear();
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with a valid instruction present: everything must read 0.
        rst_n = 1'b0;
        bus.issue_valid = 1'b1; bus.RsD = 5'd5; bus.useRs = 1'b1; bus.RtD = 5'd0;
        bus.useRt = 1'b0; bus.RdD = 5'd0; bus.writesReg = 1'b0; bus.lat = '0;
        bus.is_md = 1'b0; bus.flushD = 1'b0;
        @(posedge clk);
        #2;
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0));

        // RAW: producer to R8 lat 2, consumer stalls twice then issues.
        step(mk(1, 0, 0, 0, 0, 8, 1, 2, 0, 0));
        repeat (3) step(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        step(nop);

        // Bypass (lat 0) and $0 producers never stall consumers.
        step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0));
        step(mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 0));
        step(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));

        // Structural: second MD waits out the busy window; independent non-MD issues meanwhile.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0));
        repeat (9) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(nop);

        // Flush priority over a pending RAW.
        step(mk(1, 0, 0, 0, 0, 8, 1, 3, 0, 0));
        step(mk(1, 8, 1, 8, 1, 8, 1, 7, 0, 1));
        repeat (3) step(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0));

        // WAW on R10, then a long-latency stall run to saturate the 4-bit counter.
        step(mk(1, 0, 0, 0, 0, 10, 1, 3, 0, 0));
        repeat (4) step(mk(1, 0, 0, 0, 0, 10, 1, 5, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 7, 0, 0));
        repeat (8) step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-stall wipes pending state; the next instruction issues.
        step(mk(1, 0, 0, 0, 0, 2, 1, 7, 0, 0));
        step(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        step(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0));

        // Random traffic over a small register set, with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            i.v   = ($urandom_range(0, 7) != 0);
            i.rs  = rnd_reg();
            i.urs = $urandom_range(0, 1);
            i.rt  = rnd_reg();
            i.urt = $urandom_range(0, 1);
            i.rd  = rnd_reg();
            i.wr  = $urandom_range(0, 1);
            i.l   = 3'($urandom_range(0, 7));
            i.md  = ($urandom_range(0, 5) == 0);
            i.fl  = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step(i);
        end
        rst_n = 1'b1;
        step(nop);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Decode-stage issue controller for the 5-stage MIPS pipeline.
- Tracks, per GPR, how many cycles remain until an in-flight result is readable. Also tracks occupancy of the multi-cycle multiply/divide unit (MDU).
- Each cycle it decides whether the instruction in D issues or stalls, drives stallF/stallD/flushE to the pipeline registers, and keeps a stall performance counter.
- Replaces compare-against-every-stage hazard logic with per-register countdown state.

Parameters:
LAT_W, 3, width of per-register latency counters and of the lat input (max latency 2^LAT_W-1)
MD_LAT, 8, cycles the MDU stays busy after an accepted mult/div issue (1..255)
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
issue_valid  input  1  valid instruction present in D
RsD  input  5  source register 1 of D instruction
RtD  input  5  source register 2 of D instruction
useRs  input  1  D instruction reads RsD
useRt  input  1  D instruction reads RtD
writesReg  input  1  D instruction writes a GPR
RdD  input  5  destination GPR of D instruction
lat  input  LAT_W  producer latency: cycles a back-to-back consumer must wait (0 = fully bypassed)
is_md  input  1  D instruction uses the MDU
flushD  input  1  branch/jump redirect squashes D this cycle
stallF  output  1  hold PC / IF-ID register
stallD  output  1  hold ID-EX inputs (D instruction retained)
flushE  output  1  insert bubble into EX
issued  output  1  D instruction accepted this cycle
md_busy  output  1  MDU occupied
stall_cycles  output  PERF_W  saturating count of stall cycles

Behaviour:
- State:
  - cnt[1..31], each LAT_W bits; register 0 has no counter and is never pending.
  - md_cnt, 8 bits.
  - stall_cycles.
- Reset (rst_n=0 at edge): all cnt=0, md_cnt=0, stall_cycles=0.
- While rst_n=0, all combinational outputs are forced to 0: stallF, stallD, flushE, issued, md_busy.
- Combinational decision, same cycle as inputs:
  - raw = (useRs & RsD!=0 & cnt[RsD]!=0) | (useRt & RtD!=0 & cnt[RtD]!=0)
  - waw = writesReg & RdD!=0 & cnt[RdD]!=0
  - struct = is_md & md_busy
  - hazard = issue_valid & (raw | waw | struct)
  - md_busy = (md_cnt!=0)
- Outputs:
  - stallF = stallD = flushE = hazard & ~flushD.
  - issued = issue_valid & ~hazard & ~flushD.
  - flushD has priority: a squashed instruction neither stalls nor updates state.
- Sequential update at each rising edge, rst_n=1, applied in this order:
  1. Every cnt[r]!=0 decrements by 1; md_cnt!=0 decrements by 1.
  2. If issued & writesReg & RdD!=0 & lat!=0: cnt[RdD] = lat. This set wins over the step-1 decrement.
  3. If issued & writesReg & lat==0: no scoreboard change.
  4. If issued & is_md: md_cnt = MD_LAT. This set wins over the step-1 decrement.
- Latency semantics:
  - Producer accepted in cycle t with lat=L means dependents in D stall in cycles t+1..t+L and may issue in t+L+1.
  - A dependent in D during cycle t itself is the producer's successor; it sees the pre-update cnt.
- Counters never underflow: a counter at 0 stays 0.
- stall_cycles increments by 1 at every edge where stallD=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-stall clears all pending state. The first cycle after rst_n rises, any valid instruction issues.
- Instruction with writesReg=1 and RdD=0 issues with no scoreboard effect.
- An instruction with RsD==RtD==pending reg counts as one hazard; stall_cycles still increments by 1 per cycle.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with issue_valid=1, RsD=5 -> all outputs 0. After release: cnt all 0, issued=1, stall_cycles=0.
2. RAW:
   - Cycle 0: issue writesReg=1, RdD=8, lat=2 -> issued=1.
   - Cycles 1-2: useRs=1, RsD=8 -> stallF=stallD=flushE=1, issued=0.
   - Cycle 3: issued=1. stall_cycles=2.
3. Bypass and $0:
   - lat=0 producer to R9, then a consumer of R9 -> no stall.
   - Producer RdD=0, lat=5, then a consumer of R0 -> no stall.
4. Structural:
   - is_md issue at cycle 0 with MD_LAT=8 -> md_busy=1 for cycles 1-8.
   - Second is_md stalls cycles 1-8 and issues cycle 9. A non-MD independent instruction at cycle 1 issues.
5. Flush priority:
   - R8 pending with cnt=3, D reads R8, flushD=1 -> stallF=stallD=flushE=0, issued=0.
   - No cnt reload; stall_cycles unchanged.
6. Saturation and WAW:
   - Preload stall_cycles near max (PERF_W=4 build): counter holds 15 under continued stalls.
   - RdD=10 pending with cnt=3 and a new writer to R10 -> stalls until cnt[10]=0, then sets cnt[10]=new lat.
